// File: rtl/mem_port.sv
// Memory port: serialises each cycle's core write/read requests onto a valid/ready
// main-memory bus and routes the in-order read responses back as tagged load pulses.
module mem_port #(
    parameter int MAIN_ADDR_WIDTH = 32,
    parameter int WORD_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_out,
    input  logic [MAIN_ADDR_WIDTH-1:0] write_address,
    input  logic [WORD_WIDTH-1:0]      write_value,
    input  logic [MAIN_ADDR_WIDTH-1:0] read_address,
    input  logic                       conveyor_memload,
    input  logic                       dstack_memload,
    input  logic                       reload,
    input  logic                       stream_out,
    input  logic [1:0]                 choice,
    output logic                       stall,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_write,
    output logic [MAIN_ADDR_WIDTH-1:0] mem_req_address,
    output logic [WORD_WIDTH-1:0]      mem_req_value,
    input  logic                       mem_resp_valid,
    input  logic [WORD_WIDTH-1:0]      mem_resp_data,
    output logic                       conveyor_load_valid,
    output logic                       dstack_load_valid,
    output logic                       reload_valid,
    output logic                       stream_load_valid,
    output logic [1:0]                 reload_choice,
    output logic [WORD_WIDTH-1:0]      load_data,
    output logic                       resp_error
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] KIND_CONVEYOR = 2'd0;
    localparam logic [1:0] KIND_DSTACK   = 2'd1;
    localparam logic [1:0] KIND_RELOAD   = 2'd2;
    localparam logic [1:0] KIND_STREAM   = 2'd3;

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t state, state_next;

    logic                       read_req;
    logic [3:0]                 read_tag;
    logic [3:0]                 tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       can_push;
    logic [3:0]                 push_tag;
    logic [3:0]                 pop_tag;
    logic                       latch_pend;
    logic [MAIN_ADDR_WIDTH-1:0] pend_address;
    logic [3:0]                 pend_tag;

    assign read_req = reload | dstack_memload | conveyor_memload | stream_out;
    assign full     = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty    = (count == '0);
    assign pop      = reset && mem_resp_valid && !empty;
    // A pop in the same cycle frees the slot a push needs, so a full FIFO can still accept.
    assign can_push = !full || pop;
    assign pop_tag  = tag_mem[rd_ptr];

    // Tag = {kind, choice}; choice only matters for reload reads.
    always_comb begin
        read_tag = {KIND_STREAM, 2'b00};
        if (reload) begin
            read_tag = {KIND_RELOAD, choice};
        end else if (dstack_memload) begin
            read_tag = {KIND_DSTACK, 2'b00};
        end else if (conveyor_memload) begin
            read_tag = {KIND_CONVEYOR, 2'b00};
        end
    end

    always_comb begin
        state_next      = state;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_address = '0;
        mem_req_value   = '0;
        stall           = 1'b0;
        push            = 1'b0;
        push_tag        = read_tag;
        latch_pend      = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (write_out) begin
                        // In a dual-op cycle the read's FIFO slot is reserved before the write goes out.
                        if (read_req && !can_push) begin
                            stall = 1'b1;
                        end else begin
                            mem_req_valid   = 1'b1;
                            mem_req_write   = 1'b1;
                            mem_req_address = write_address;
                            mem_req_value   = write_value;
                            if (!mem_req_ready) begin
                                stall = 1'b1;
                            end else if (read_req) begin
                                latch_pend = 1'b1;
                                state_next = PEND;
                            end
                        end
                    end else if (read_req) begin
                        if (!can_push) begin
                            stall = 1'b1;
                        end else begin
                            mem_req_valid   = 1'b1;
                            mem_req_address = read_address;
                            stall           = !mem_req_ready;
                            push            = mem_req_ready;
                        end
                    end
                end
                PEND: begin
                    mem_req_valid   = 1'b1;
                    mem_req_address = pend_address;
                    push_tag        = pend_tag;
                    stall           = write_out || read_req;
                    if (mem_req_ready) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pend_address <= '0;
            pend_tag     <= '0;
        end else begin
            state <= state_next;
            if (latch_pend) begin
                pend_address <= read_address;
                pend_tag     <= read_tag;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Response side: one registered pulse per popped tag, data held until the next pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            conveyor_load_valid <= 1'b0;
            dstack_load_valid   <= 1'b0;
            reload_valid        <= 1'b0;
            stream_load_valid   <= 1'b0;
            reload_choice       <= 2'b00;
            load_data           <= '0;
            resp_error          <= 1'b0;
        end else begin
            conveyor_load_valid <= pop && (pop_tag[3:2] == KIND_CONVEYOR);
            dstack_load_valid   <= pop && (pop_tag[3:2] == KIND_DSTACK);
            reload_valid        <= pop && (pop_tag[3:2] == KIND_RELOAD);
            stream_load_valid   <= pop && (pop_tag[3:2] == KIND_STREAM);
            reload_choice       <= (pop && (pop_tag[3:2] == KIND_RELOAD)) ? pop_tag[1:0] : 2'b00;
            if (pop) begin
                load_data <= mem_resp_data;
            end
            if (mem_resp_valid && empty) begin
                resp_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_port.md
# mem_port

Sequential memory port directly downstream of the core's combinational memory-control stage. It turns each cycle's write and read requests into valid/ready transactions on the main-memory bus. Reads go out tagged with their destination: conveyor, data stack, DC reload (with choice) or stream-out. In-order responses come back as one-cycle load pulses. The block serialises cycles that carry both a write and a read, tracks outstanding reads, and stalls the core when it cannot accept a request.

## Interface
- MAIN_ADDR_WIDTH, 32, main-memory word address width
- WORD_WIDTH, 32, data word width
- MAX_OUTSTANDING, 4, tag FIFO depth (power of two, 2..16)

- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-low (asserted when 0)
- write_out  in  1  write request this cycle
- write_address  in  MAIN_ADDR_WIDTH  write address
- write_value  in  WORD_WIDTH  write data
- read_address  in  MAIN_ADDR_WIDTH  read address
- conveyor_memload, dstack_memload, reload, stream_out  in  1 each  read request kinds
- choice  in  2  DC index for reload reads
- stall  out  1  combinational; core must hold all request inputs stable next cycle
- mem_req_valid  out  1; mem_req_ready  in  1  request handshake
- mem_req_write  out  1; mem_req_address  out  MAIN_ADDR_WIDTH; mem_req_value  out  WORD_WIDTH
- mem_resp_valid  in  1; mem_resp_data  in  WORD_WIDTH  in-order read responses, any latency ≥1
- conveyor_load_valid, dstack_load_valid, reload_valid, stream_load_valid  out  1 each  registered one-cycle pulses
- reload_choice  out  2  DC index accompanying reload_valid
- load_data  out  WORD_WIDTH  registered response data
- resp_error  out  1  sticky: a response arrived with no read outstanding

## Operation
- A read is requested when any read kind is set. Kind priority when several are set: reload > dstack > conveyor > stream. Tag = {kind[1:0], choice}; choice is kept only for reload.
- States: IDLE, PEND (latched read waiting to issue).
- IDLE, write only: drive write on bus combinationally. stall = !mem_req_ready.
- IDLE, read only: drive read. Accept when mem_req_ready and FIFO not full; on accept push tag. Otherwise stall=1.
- IDLE, write+read: issue the write first. On write handshake with FIFO not full (counting the reserved slot), latch read address+tag, go to PEND, stall=0. If the write is not accepted or the FIFO is full, stall=1 and nothing is latched.
- PEND: drive the latched read. On handshake push its tag and return to IDLE. Any core request while in PEND gives stall=1; it is processed in IDLE.
- Response: pop tag, register data into load_data, pulse the matching *_valid next cycle. A response with FIFO empty is dropped and sets resp_error.
- Push and pop in the same cycle: count unchanged; a full FIFO may accept a push in a cycle with a pop.
- mem_req_valid=0 when there is no request or stall is due to FIFO full.

## Timing
- Reset (reset=0 at an edge): state=IDLE, FIFO count=0, pending cleared, all *_valid=0, reload_choice=0, load_data=0, resp_error=0. While reset=0: mem_req_valid=0 and stall=0, and responses are ignored.
- Reset mid-transaction flushes outstanding tags. Late responses after release set resp_error.
- Request latency: 0 cycles (combinational to the bus in IDLE). The read in a dual-op cycle issues ≥1 cycle after its write.
- Response latency: mem_resp_valid at edge t gives the load pulse and load_data valid during cycle t+1.
- Throughput: one request per cycle; back-to-back responses give back-to-back pulses.
- Address/data pass through unmodified, with no width conversion. The FIFO pointers wrap modulo MAX_OUTSTANDING.

## Test plan
- Reset: hold reset=0 with the FIFO holding 2 tags → after release, all outputs are 0. A response then gives no pulse and sets resp_error=1.
- Dstack read at 0x10 with mem_req_ready=1 → mem_req_valid=1, write=0, addr=0x10. A response of 0xDEADBEEF 3 cycles later → dstack_load_valid pulses once with load_data=0xDEADBEEF.
- Dual op: write 0x5 to 0x20 plus reload choice=2 read at 0x24 → cycle0 write 0x20, stall=0, cycle1 read 0x24 (PEND). A response of 0x77 → reload_valid=1, reload_choice=2, load_data=0x77.
- Full: issue 4 conveyor reads with no responses, then a 5th → stall=1, mem_req_valid=0. Give a response in the same cycle → the 5th read is accepted and the count stays 4.
- Backpressure: write with mem_req_ready=0 for 3 cycles → stall=1 for 3 cycles, request stable, exactly one write accepted.
- Ordering: conveyor, stream, reload(choice=1) reads with responses A, B, C back-to-back → pulses conveyor/A, stream/B, reload/C on consecutive cycles.
